rail_stepper_scheduler: RTL and testbench

//  Shares one 4-phase rail-switch stepper between NREQ requesters (keypad digit loader, VGA UI, ...).

---
 rtl/rail_stepper_scheduler_pkg.sv | 17 +
 rtl/rail_stepper_scheduler_if.sv | 32 +++
 rtl/rail_stepper_scheduler_phase_gen.sv | 32 +++
 rtl/rail_stepper_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_rail_stepper_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rail_stepper_scheduler_pkg.sv
// Shared types and constants for the rail-switch stepper scheduler.
package rail_ctrl_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        IDLE,
        CALC,
        STEP,
        WAIT,
        SETTLE,
        DONE
    } sched_state_t;

    // Coil drive {A1,B1,A2,B2} for phase index 0..3 (index 0 is the rightmost entry).
    localparam logic [3:0][3:0] COIL_PATTERN = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

endpackage

// File: rtl/rail_stepper_scheduler_if.sv
// Request/completion bus between the requesters and the stepper scheduler.
interface rail_stepper_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int POS_W = 14
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*POS_W-1:0]    req_target;
    logic [NREQ-1:0]          req_ready;
    logic                     hold;
    logic                     abort;
    logic                     busy;
    logic                     done;
    logic [$clog2(NREQ)-1:0]  done_id;
    logic                     done_abort;
    logic [POS_W-1:0]         cur_pos;
    logic                     A1;
    logic                     B1;
    logic                     A2;
    logic                     B2;

    // Requester side.
    modport master (
        output req_valid, req_target, hold, abort,
        input  req_ready, busy, done, done_id, done_abort, cur_pos, A1, B1, A2, B2
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_target, hold, abort,
        output req_ready, busy, done, done_id, done_abort, cur_pos, A1, B1, A2, B2
    );
endinterface

// File: rtl/rail_stepper_scheduler_phase_gen.sv
// 4-phase full-step generator: keeps the phase index, drives the coils while energized.
module stepper_phase_gen
    import rail_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic dir,
    input  logic energize,
    output logic A1,
    output logic B1,
    output logic A2,
    output logic B2
);

    logic [1:0] phase_reg;

    // Advance the phase on each step pulse; the index survives between moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg <= 2'd0;
        end else if (step) begin
            phase_reg <= dir ? phase_reg + 2'd1 : phase_reg - 2'd1;
        end
    end

    // Coils follow the table only while a move is active.
    always_comb begin
        {A1, B1, A2, B2} = energize ? COIL_PATTERN[phase_reg] : 4'b0000;
    end

endmodule

// File: rtl/rail_stepper_scheduler.sv
// Round-robin shared stepper scheduler: arbitrates absolute moves, paces steps, settles, reports.
module rail_stepper_scheduler
    import rail_ctrl_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int POS_W         = 14,
    parameter int MAX_POS       = 200,
    parameter int STEP_DIV      = 262144,
    parameter int SETTLE_CYCLES = 65536
) (
    input  logic                      clk,
    input  logic                      reset,
    rail_stepper_scheduler_if.slave   bus
);

    localparam int ID_W    = $clog2(NREQ);
    localparam int TMR_MAX = (STEP_DIV > SETTLE_CYCLES) ? STEP_DIV : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    sched_state_t       state_reg, state_next;
    logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]    owner_reg, owner_next;
    logic [POS_W-1:0]   tgt_reg, tgt_next;
    logic [POS_W-1:0]   cur_pos_reg, cur_pos_next;
    logic [POS_W-1:0]   remaining_reg, remaining_next;
    logic               dir_reg, dir_next;
    logic               aborted_reg, aborted_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;

    logic [POS_W-1:0]   target_arr [NREQ];
    logic [NREQ-1:0]    ready_raw;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [POS_W-1:0]   sel_target;
    logic [POS_W-1:0]   clamped_target;
    logic signed [POS_W:0] delta;
    logic [POS_W:0]     neg_delta;
    logic [POS_W-1:0]   abs_delta;
    logic               energize;
    logic               coil_a1, coil_b1, coil_a2, coil_b2;

    genvar gi;

    // Split the packed target bus into one entry per requester; gate ready during reset.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign target_arr[gi]    = bus.req_target[gi*POS_W +: POS_W];
            assign bus.req_ready[gi] = ready_raw[gi] & ~reset;
        end
    endgenerate

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping around.
    always_comb begin : arb_scan
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_reg) + i) % NREQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign sel_target     = target_arr[grant_idx];
    assign clamped_target = (sel_target > POS_W'(MAX_POS)) ? POS_W'(MAX_POS) : sel_target;
    assign delta          = $signed({1'b0, tgt_reg}) - $signed({1'b0, cur_pos_reg});
    assign neg_delta      = -delta;
    assign abs_delta      = delta[POS_W] ? neg_delta[POS_W-1:0] : delta[POS_W-1:0];

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            tgt_reg       <= '0;
            cur_pos_reg   <= '0;
            remaining_reg <= '0;
            dir_reg       <= 1'b0;
            aborted_reg   <= 1'b0;
            timer_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            owner_reg     <= owner_next;
            tgt_reg       <= tgt_next;
            cur_pos_reg   <= cur_pos_next;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
            aborted_reg   <= aborted_next;
            timer_reg     <= timer_next;
        end
    end

    // Next-state and datapath update; abort beats hold wherever both are sampled.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        owner_next     = owner_reg;
        tgt_next       = tgt_reg;
        cur_pos_next   = cur_pos_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;
        aborted_next   = aborted_reg;
        timer_next     = timer_reg;
        ready_raw      = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    ready_raw[grant_idx] = 1'b1;
                    owner_next           = grant_idx;
                    tgt_next             = clamped_target;
                    aborted_next         = 1'b0;
                    state_next           = CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    aborted_next = 1'b1;
                    state_next   = DONE;
                end else if (delta == '0) begin
                    state_next = DONE;
                end else begin
                    dir_next       = ~delta[POS_W];
                    remaining_next = abs_delta;
                    if (!bus.hold) begin
                        state_next = STEP;
                    end
                end
            end
            STEP: begin
                // The step taken in this cycle always lands, even when aborting.
                cur_pos_next   = dir_reg ? cur_pos_reg + POS_W'(1) : cur_pos_reg - POS_W'(1);
                remaining_next = remaining_reg - POS_W'(1);
                if (bus.abort) begin
                    aborted_next = 1'b1;
                    state_next   = DONE;
                end else if (remaining_reg == POS_W'(1)) begin
                    timer_next = TMR_W'(SETTLE_CYCLES - 1);
                    state_next = SETTLE;
                end else begin
                    // STEP itself is one cycle of the step period.
                    timer_next = TMR_W'(STEP_DIV - 2);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.abort) begin
                    aborted_next = 1'b1;
                    state_next   = DONE;
                end else if (bus.hold) begin
                    timer_next = timer_reg;
                end else if (timer_reg == '0) begin
                    state_next = STEP;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    aborted_next = 1'b1;
                    state_next   = DONE;
                end else if (timer_reg == '0) begin
                    state_next = DONE;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            DONE: begin
                rr_ptr_next = (owner_reg == ID_W'(NREQ - 1)) ? '0 : owner_reg + ID_W'(1);
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign energize       = (state_reg != IDLE);
    assign bus.busy       = energize;
    assign bus.done       = (state_reg == DONE);
    assign bus.done_id    = (state_reg == DONE) ? owner_reg : '0;
    assign bus.done_abort = (state_reg == DONE) & aborted_reg;
    assign bus.cur_pos    = cur_pos_reg;
    assign bus.A1         = coil_a1;
    assign bus.B1         = coil_b1;
    assign bus.A2         = coil_a2;
    assign bus.B2         = coil_b2;

    stepper_phase_gen u_phase_gen (
        .clk      (clk),
        .reset    (reset),
        .step     (state_reg == STEP),
        .dir      (dir_reg),
        .energize (energize),
        .A1       (coil_a1),
        .B1       (coil_b1),
        .A2       (coil_a2),
        .B2       (coil_b2)
    );

endmodule

// File: tb/tb_rail_stepper_scheduler.sv
// Randomized scoreboard bench for rail_stepper_scheduler with a move-level reference model.
module tb_rail_stepper_scheduler;

    localparam int NREQ   = 2;
    localparam int POS_W  = 14;
    localparam int MAXP   = 200;
    localparam int SDIV   = 4;
    localparam int SETL   = 3;

    typedef struct {
        int id;
        int ab;
        int pos;
        int lat;
        int steps;
        int coil;
        int acc;
    } exp_t;

    logic clk;
    logic reset;

    rail_stepper_scheduler_if #(.NREQ(NREQ), .POS_W(POS_W)) bus ();

    rail_stepper_scheduler #(
        .NREQ(NREQ), .POS_W(POS_W), .MAX_POS(MAXP),
        .STEP_DIV(SDIV), .SETTLE_CYCLES(SETL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   done_cnt     = 0;
    int   pos_m        = 0;
    int   phase_m      = 0;
    int   rr_m         = 0;
    int   coil_tab [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: counts coil changes as steps, pops the scoreboard on every done pulse.
    initial begin
        logic [3:0] coil;
        logic [3:0] prev_coil;
        int   step_cnt;
        bit   energ_ok;
        bit   post_chk;
        exp_t e;
        prev_coil = 4'b0;
        step_cnt  = 0;
        energ_ok  = 1'b1;
        post_chk  = 1'b0;
        forever begin
            @(negedge clk);
            coil = {bus.A1, bus.B1, bus.A2, bus.B2};
            if (reset) begin
                step_cnt  = 0;
                prev_coil = 4'b0;
                energ_ok  = 1'b1;
                post_chk  = 1'b0;
            end else begin
                if (post_chk) begin
                    check("idle_coils", coil, 0);
                    check("idle_busy", bus.busy, 0);
                    post_chk = 1'b0;
                end
                if (bus.busy && prev_coil != 4'b0 && coil != prev_coil) step_cnt++;
                if (bus.busy && coil == 4'b0) energ_ok = 1'b0;
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_id", bus.done_id, e.id);
                        check("done_abort", bus.done_abort, e.ab);
                        check("cur_pos", bus.cur_pos, e.pos);
                        check("latency", cyc - e.acc, e.lat);
                        check("steps", step_cnt, e.steps);
                        check("coils", coil, e.coil);
                        check("energized", energ_ok, 1);
                        $display("[TB] move id=%0d pos=%0d steps=%0d lat=%0d abort=%0d", e.id, e.pos,
                                 e.steps, e.lat, e.ab);
                    end
                    done_cnt++;
                    step_cnt = 0;
                    energ_ok = 1'b1;
                    post_chk = 1'b1;
                end
                prev_coil = coil;
            end
        end
    end

    task automatic wait_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_mid();
        int bad;
        reset = 1'b1;
        #1;
        check("rst_outputs", {bus.busy, bus.done, bus.done_abort, bus.done_id, bus.cur_pos,
                              bus.A1, bus.B1, bus.A2, bus.B2, bus.req_ready}, 0);
        exp_q.delete();
        bus.req_valid = '0;
        bus.hold      = 1'b0;
        bus.abort     = 1'b0;
        wait_edge();
        wait_edge();
        reset   = 1'b0;
        pos_m   = 0;
        phase_m = 0;
        rr_m    = 0;
        bad     = 0;
        repeat (10) begin
            wait_edge();
            if (bus.done || bus.req_ready != '0 || bus.busy) bad++;
        end
        check("post_rst_quiet", bad, 0);
        check("post_rst_pos", bus.cur_pos, 0);
        $display("[TB] reset mid-move released");
    endtask

    // One granted move: check the grant, push the model's expectation, drive hold/abort/reset.
    task automatic serve(input int g, input int t, input int h, input int a, input int r);
        int   waited, c, n, up, lat, steps, ab, k, d0;
        exp_t e;
        waited = 0;
        while (bus.req_ready == '0 && waited < 50) begin
            wait_edge();
            waited++;
        end
        check("grant", bus.req_ready, 1 << g);
        c     = (t > MAXP) ? MAXP : t;
        up    = (c >= pos_m) ? 1 : 0;
        n     = up ? c - pos_m : pos_m - c;
        lat   = (n == 0) ? 2 : 2 + (n - 1) * SDIV + SETL + 1;
        steps = n;
        ab    = 0;
        if (a >= 1 && a < lat) begin
            ab    = 1;
            steps = (a < 2) ? 0 : (((a - 2) / SDIV + 1) < n ? ((a - 2) / SDIV + 1) : n);
            lat   = a + 1;
        end else if (h > 0 && n >= 2) begin
            lat = lat + h;
        end
        if (r < 0) begin
            pos_m   = up ? pos_m + steps : pos_m - steps;
            phase_m = (((phase_m + (up ? steps : -steps)) % 4) + 4) % 4;
            rr_m    = (g + 1) % NREQ;
            e.id = g; e.ab = ab; e.pos = pos_m; e.lat = lat; e.steps = steps;
            e.coil = coil_tab[phase_m]; e.acc = cyc;
            exp_q.push_back(e);
        end
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 3000) begin
            wait_edge();
            k++;
            if (k == 1) bus.req_valid[g] = 1'b0;
            bus.hold  = (h > 0 && k >= 3 && k < 3 + h);
            bus.abort = (k == a);
            if (k == r) begin
                reset_mid();
                return;
            end
        end
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        check("done_seen", (done_cnt != d0) ? 1 : 0, 1);
    endtask

    // Present up to two requests at once and serve them in model round-robin order.
    task automatic round(input logic [1:0] vmask, input int t0, input int t1,
                         input int h, input int a, input int r);
        logic [1:0] m;
        int g;
        int hh, aa, rr;
        bus.req_target = {POS_W'(t1), POS_W'(t0)};
        bus.req_valid  = vmask;
        #1;
        m  = vmask;
        hh = h; aa = a; rr = r;
        while (m != 2'b00) begin
            g = m[rr_m] ? rr_m : 1 - rr_m;
            serve(g, (g == 0) ? t0 : t1, hh, aa, rr);
            m[g] = 1'b0;
            hh = 0; aa = -1; rr = -1;
        end
    endtask

    initial begin
        logic [1:0] vm;
        int t0, t1, h, a;
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_target = '0;
        bus.hold       = 1'b0;
        bus.abort      = 1'b0;
        wait_edge();
        wait_edge();
        check("reset_state", {bus.busy, bus.done, bus.done_abort, bus.done_id, bus.cur_pos,
                              bus.A1, bus.B1, bus.A2, bus.B2, bus.req_ready}, 0);
        reset = 1'b0;
        wait_edge();

        round(2'b01, 3, 0, 0, -1, -1);     // 0 -> 3, step every 4 cycles, done at 14
        round(2'b10, 0, 0, 0, -1, -1);     // back to 0 via requester 1, pointer returns to 0
        round(2'b11, 5, 2, 0, -1, -1);     // both valid: req0 then req1, ends at 2
        round(2'b01, 2, 0, 0, -1, -1);     // target equals position: no step
        round(2'b10, 0, 999, 0, -1, -1);   // clamped to 200
        round(2'b01, 190, 0, 10, -1, -1);  // hold 10 cycles in the first wait
        round(2'b10, 0, 0, 0, -1, -1);     // back to 0
        round(2'b01, 6, 0, 0, 7, -1);      // abort after the second step
        round(2'b01, 10, 0, 0, -1, 7);     // reset in the middle of a wait
        round(2'b01, 1, 0, 0, -1, -1);     // phase index restarts at 0 after reset

        repeat (24) begin
            vm = 2'($urandom_range(1, 3));
            t0 = $urandom_range(0, 220);
            t1 = $urandom_range(0, 220);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(1, 14);
                h = 0;
            end else begin
                a = -1;
                h = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
            end
            round(vm, t0, t1, h, a, -1);
        end

        repeat (5) wait_edge();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
